dfr_reservoir_sequencer: RTL and testbench
==========================================

# dfr_reservoir_sequencer

Responder-side sequencer for the DFR reservoir. It receives the controller's reservoir strobes (`reservoir_rst`, `reservoir_en`, `reservoir_history_en`, `sample_cntr_rst`) and answers with `reservoir_init_busy`, `reservoir_busy` and `reservoir_filled`. It also counts virtual nodes and samples, produces input-memory read addresses and reservoir-history write addresses, and detects warm-up and run completion. It sits between the DFR core controller and the reservoir datapath and memories.

## Interface
Parameters:
- `ADDR_WIDTH`, 32: width of `input_addr` and `history_addr`.
- `SAMPLE_WIDTH`, 16: width of sample counts and `sample_cntr`.
- `VIRTUAL_NODES`, 10: virtual nodes per sample; must be ≥ 2.
- `NODE_WIDTH`, `$clog2(VIRTUAL_NODES)`: width of `node_cntr`.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `reservoir_rst` in 1: synchronous run restart.
- `reservoir_en` in 1: advance one virtual node.
- `reservoir_history_en` in 1: record the current node into history.
- `sample_cntr_rst` in 1: synchronous counter clear; also triggers the phase change.
- `num_init_samples` in SAMPLE_WIDTH: warm-up sample count.
- `num_samples` in SAMPLE_WIDTH: recorded-run sample count.
- `reservoir_init_busy` out 1: warm-up in progress.
- `reservoir_busy` out 1: sequencer busy in INIT or RUN.
- `reservoir_filled` out 1: delay line full while in RUN.
- `input_rd_en` out 1: input-memory read strobe.
- `input_addr` out ADDR_WIDTH: input-memory sample address.
- `history_wr_en` out 1: history-memory write strobe.
- `history_addr` out ADDR_WIDTH: history-memory write address.
- `node_cntr` out NODE_WIDTH: current virtual node index.
- `sample_cntr` out SAMPLE_WIDTH: current sample index within the phase.

## Operation
- States are IDLE, INIT, RUN and DONE. Async `rst` forces IDLE, clears all counters and `fill_flag`, and clears the latched counts.
- Priority on each clock edge: `reservoir_rst`, then `sample_cntr_rst`, then `reservoir_en`.
- `reservoir_rst` (any state):
  - next state INIT;
  - `node_cntr`, `sample_cntr`, `history_addr` and `fill_flag` cleared;
  - `num_init_samples` and `num_samples` latched. Latched values are used until the next `reservoir_rst`.
- `sample_cntr_rst` clears `node_cntr` and `sample_cntr`. If it arrives in INIT with `reservoir_init_busy`=0, the next state is RUN. In every other state it changes no state.
- Advance condition: `reservoir_en` && `reservoir_busy` && no higher-priority strobe.
  - Each advance increments `node_cntr`.
  - At VIRTUAL_NODES-1, `node_cntr` wraps to 0, `sample_cntr` increments and `fill_flag` sets. `fill_flag` is sticky until `reservoir_rst`/`rst`.
  - `reservoir_en` is ignored when not busy; counters hold.
- Combinational outputs, all decoded from registered state:
  - `reservoir_init_busy` = INIT && (`sample_cntr` < latched init).
  - `reservoir_busy` = INIT || (RUN && `sample_cntr` < latched num).
  - `reservoir_filled` = RUN && `fill_flag`.
  - `input_rd_en` = `reservoir_en` && `reservoir_busy`.
  - `input_addr` = zero-extended `sample_cntr`, plus latched init when in RUN.
  - `history_wr_en` = `reservoir_en` && `reservoir_history_en` && RUN && `reservoir_busy`.
- `history_addr` increments by 1 after every cycle with `history_wr_en`=1. It wraps modulo 2^ADDR_WIDTH and is never cleared by `sample_cntr_rst`.
- RUN moves to DONE on the edge after `reservoir_busy` falls, i.e. when `sample_cntr` equals latched num. DONE holds until `reservoir_rst`. IDLE and DONE drive all busy/strobe outputs to 0.

## Timing
- Every registered output is 0 after `rst`. Every combinational output is 0 in IDLE.
- The cycle after `reservoir_rst` shows INIT with all counters 0. `reservoir_init_busy` is 1 unless latched init is 0.
- Warm-up length is exactly init×VIRTUAL_NODES accepted enables. `reservoir_init_busy` falls in the cycle after the final accepted enable edge.
- RUN length is num×VIRTUAL_NODES accepted enables. `reservoir_busy` falls the cycle after the last one, and DONE follows on the next edge.
- `history_wr_en` and `input_rd_en` are same-cycle with their strobes; the address is valid in that cycle.
- Boundary cases:
  - Init=0: INIT shows `reservoir_busy`=1 and `reservoir_init_busy`=0 immediately.
  - Init=0: `fill_flag` is still 0 on entry to RUN, so the first RUN sample has `reservoir_filled`=0 and produces no history writes.
  - Num=0: RUN has `reservoir_busy`=0 and goes to DONE on the next edge with zero writes.
  - `reservoir_rst` together with `sample_cntr_rst` acts as `reservoir_rst` only.
  - `reservoir_rst` mid-RUN aborts immediately. No write occurs in that cycle, even with `reservoir_en`=1.
  - Async `rst` mid-operation returns the block to IDLE in the same cycle.

## Test plan
- VN=4, init=2, num=3: `reservoir_rst`, then constant en → `reservoir_init_busy` high for 8 enables; `sample_cntr_rst` → RUN; `reservoir_filled`=1 from the first RUN cycle; 12 writes at `history_addr` 0..11; `input_addr` 2..4; DONE.
- Init=0, VN=4, num=2: `reservoir_filled`=0 for the first 4 RUN enables and 1 for the next 4; exactly 4 writes, `history_addr` ending at 4.
- num=0: RUN → `reservoir_busy`=0 immediately, DONE the next cycle, `history_wr_en` never asserts.
- Gapped `reservoir_en` (1 of 3 cycles) in RUN → counter progression identical to the dense case; no strobe in idle cycles; `reservoir_history_en`=0 cycles produce no write and no address increment.
- `reservoir_rst` at RUN `sample_cntr`=1 with `reservoir_en`=1 → next cycle INIT, counters 0, `history_addr`=0, no write in the abort cycle.
- Async `rst` pulse mid-INIT, between clock edges → all outputs 0 immediately; state IDLE; `reservoir_en` ignored until the next `reservoir_rst`.

Source files
------------

// File: rtl/dfr_reservoir_sequencer_if.sv
// dfr_reservoir_sequencer_if: controller-to-sequencer strobes, run lengths and the sequencer's status/address outputs.
interface dfr_reservoir_sequencer_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int SAMPLE_WIDTH = 16,
  parameter int VIRTUAL_NODES = 10,
  parameter int NODE_WIDTH = $clog2(VIRTUAL_NODES)
);
  logic reservoir_rst;
  logic reservoir_en;
  logic reservoir_history_en;
  logic sample_cntr_rst;
  logic [SAMPLE_WIDTH-1:0] num_init_samples;
  logic [SAMPLE_WIDTH-1:0] num_samples;
  logic reservoir_init_busy;
  logic reservoir_busy;
  logic reservoir_filled;
  logic input_rd_en;
  logic [ADDR_WIDTH-1:0] input_addr;
  logic history_wr_en;
  logic [ADDR_WIDTH-1:0] history_addr;
  logic [NODE_WIDTH-1:0] node_cntr;
  logic [SAMPLE_WIDTH-1:0] sample_cntr;
  modport master (
    output reservoir_rst, reservoir_en, reservoir_history_en, sample_cntr_rst, num_init_samples, num_samples,
    input reservoir_init_busy, reservoir_busy, reservoir_filled, input_rd_en, input_addr,
    history_wr_en, history_addr, node_cntr, sample_cntr
  );
  modport slave (
    input reservoir_rst, reservoir_en, reservoir_history_en, sample_cntr_rst, num_init_samples, num_samples,
    output reservoir_init_busy, reservoir_busy, reservoir_filled, input_rd_en, input_addr,
    history_wr_en, history_addr, node_cntr, sample_cntr
  );
endinterface

// File: rtl/dfr_reservoir_sequencer.sv
// dfr_reservoir_sequencer: steps virtual nodes and samples through warm-up and recorded run, emitting memory strobes/addresses.
module dfr_reservoir_sequencer #(
  parameter int ADDR_WIDTH = 32,
  parameter int SAMPLE_WIDTH = 16,
  parameter int VIRTUAL_NODES = 10,
  parameter int NODE_WIDTH = $clog2(VIRTUAL_NODES)
) (
  input logic clk,
  input logic rst,
  dfr_reservoir_sequencer_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0, INIT = 2'd1, RUN = 2'd2, DONE = 2'd3;
  logic [1:0] state;
  logic [SAMPLE_WIDTH-1:0] init_lat, num_lat, sample;
  logic [NODE_WIDTH-1:0] node;
  logic [ADDR_WIDTH-1:0] haddr;
  logic fill_flag, init_busy, busy, adv, wr, node_last;
  // Higher-priority strobes suppress the advance, so an aborted cycle never writes history.
  always_comb begin
    init_busy = state == INIT && sample < init_lat;
    busy = state == INIT || (state == RUN && sample < num_lat);
    adv = bus.reservoir_en && busy && !bus.reservoir_rst && !bus.sample_cntr_rst;
    wr = adv && bus.reservoir_history_en && state == RUN;
    node_last = node == NODE_WIDTH'(VIRTUAL_NODES - 1);
  end
  assign bus.reservoir_init_busy = init_busy;
  assign bus.reservoir_busy = busy;
  assign bus.reservoir_filled = state == RUN && fill_flag;
  assign bus.input_rd_en = bus.reservoir_en && busy;
  assign bus.input_addr = ADDR_WIDTH'(sample) + (state == RUN ? ADDR_WIDTH'(init_lat) : '0);
  assign bus.history_wr_en = wr;
  assign bus.history_addr = haddr;
  assign bus.node_cntr = node;
  assign bus.sample_cntr = sample;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      init_lat <= '0;
      num_lat <= '0;
      sample <= '0;
      node <= '0;
      haddr <= '0;
      fill_flag <= 1'b0;
    end else if (bus.reservoir_rst) begin
      state <= INIT;
      init_lat <= bus.num_init_samples;
      num_lat <= bus.num_samples;
      sample <= '0;
      node <= '0;
      haddr <= '0;
      fill_flag <= 1'b0;
    end else if (bus.sample_cntr_rst) begin
      sample <= '0;
      node <= '0;
      if (state == INIT && !init_busy) state <= RUN;
    end else begin
      if (adv) begin
        node <= node_last ? '0 : node + 1'b1;
        if (node_last) begin
          sample <= sample + 1'b1;
          fill_flag <= 1'b1;
        end
      end
      if (wr) haddr <= haddr + 1'b1;
      if (state == RUN && !busy) state <= DONE;
    end
  end
endmodule

// File: tb/tb_dfr_reservoir_sequencer.sv
// tb_dfr_reservoir_sequencer: directed vector table plus hand-written multi-cycle sequences, VIRTUAL_NODES=4.
module tb_dfr_reservoir_sequencer;
  localparam int VN = 4, AW = 32, SW = 16;
  typedef struct packed {
    logic [3:0] in;
    logic [15:0] ni, ns;
    logic [4:0] fl;
    logic [31:0] ia, ha;
    logic [1:0] nc;
    logic [15:0] sc;
  } vec_t;
  logic clk = 1'b0, rst = 1'b1, he_auto = 1'b0;
  logic [15:0] ni = '0, ns = '0;
  int checks = 0, failures = 0;
  vec_t tbl [21];
  always #5 clk = ~clk;
  dfr_reservoir_sequencer_if #(.ADDR_WIDTH(AW), .SAMPLE_WIDTH(SW), .VIRTUAL_NODES(VN)) bus ();
  dfr_reservoir_sequencer #(.ADDR_WIDTH(AW), .SAMPLE_WIDTH(SW), .VIRTUAL_NODES(VN)) dut (.clk(clk), .rst(rst), .bus(bus));
  function automatic vec_t mk(input logic [3:0] in, input logic [15:0] vni, vns, input logic [4:0] fl,
                              input logic [31:0] ia, ha, input logic [1:0] nc, input logic [15:0] sc);
    return {in, vni, vns, fl, ia, ha, nc, sc};
  endfunction
  function automatic logic [4:0] flags();
    return {bus.reservoir_init_busy, bus.reservoir_busy, bus.reservoir_filled, bus.input_rd_en, bus.history_wr_en};
  endfunction
  function automatic logic [86:0] outs();
    return {flags(), bus.input_addr, bus.history_addr, bus.node_cntr, bus.sample_cntr};
  endfunction
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask
  // History enable follows reservoir_filled when he_auto models a controller that records only a full delay line.
  task automatic drive(input logic rr, en, he, sr);
    @(negedge clk);
    bus.reservoir_rst = rr;
    bus.reservoir_en = en;
    bus.reservoir_history_en = he_auto ? bus.reservoir_filled : he;
    bus.sample_cntr_rst = sr;
    bus.num_init_samples = ni;
    bus.num_samples = ns;
    #1;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int cnt, writes, nf0, nf1, k;
    bus.reservoir_rst = 1'b0;
    bus.reservoir_en = 1'b0;
    bus.reservoir_history_en = 1'b0;
    bus.sample_cntr_rst = 1'b0;
    bus.num_init_samples = '0;
    bus.num_samples = '0;
    tbl[0]  = mk(4'b0000, 16'd0, 16'd0, 5'b00000, 32'd0, 32'd0, 2'd0, 16'd0);
    tbl[1]  = mk(4'b0100, 16'd0, 16'd0, 5'b00000, 32'd0, 32'd0, 2'd0, 16'd0);
    tbl[2]  = mk(4'b1100, 16'd1, 16'd1, 5'b00000, 32'd0, 32'd0, 2'd0, 16'd0);
    tbl[3]  = mk(4'b0100, 16'd1, 16'd1, 5'b11010, 32'd0, 32'd0, 2'd0, 16'd0);
    tbl[4]  = mk(4'b0100, 16'd1, 16'd1, 5'b11010, 32'd0, 32'd0, 2'd1, 16'd0);
    tbl[5]  = mk(4'b0100, 16'd1, 16'd1, 5'b11010, 32'd0, 32'd0, 2'd2, 16'd0);
    tbl[6]  = mk(4'b0100, 16'd1, 16'd1, 5'b11010, 32'd0, 32'd0, 2'd3, 16'd0);
    tbl[7]  = mk(4'b0000, 16'd1, 16'd1, 5'b01000, 32'd1, 32'd0, 2'd0, 16'd1);
    tbl[8]  = mk(4'b0001, 16'd1, 16'd1, 5'b01000, 32'd1, 32'd0, 2'd0, 16'd1);
    tbl[9]  = mk(4'b0110, 16'd1, 16'd1, 5'b01111, 32'd1, 32'd0, 2'd0, 16'd0);
    tbl[10] = mk(4'b0100, 16'd1, 16'd1, 5'b01110, 32'd1, 32'd1, 2'd1, 16'd0);
    tbl[11] = mk(4'b0110, 16'd1, 16'd1, 5'b01111, 32'd1, 32'd1, 2'd2, 16'd0);
    tbl[12] = mk(4'b0010, 16'd1, 16'd1, 5'b01100, 32'd1, 32'd2, 2'd3, 16'd0);
    tbl[13] = mk(4'b0110, 16'd1, 16'd1, 5'b01111, 32'd1, 32'd2, 2'd3, 16'd0);
    tbl[14] = mk(4'b0110, 16'd1, 16'd1, 5'b00100, 32'd2, 32'd3, 2'd0, 16'd1);
    tbl[15] = mk(4'b0100, 16'd1, 16'd1, 5'b00000, 32'd1, 32'd3, 2'd0, 16'd1);
    tbl[16] = mk(4'b1101, 16'd0, 16'd0, 5'b00000, 32'd1, 32'd3, 2'd0, 16'd1);
    tbl[17] = mk(4'b0000, 16'd0, 16'd0, 5'b01000, 32'd0, 32'd0, 2'd0, 16'd0);
    tbl[18] = mk(4'b0001, 16'd0, 16'd0, 5'b01000, 32'd0, 32'd0, 2'd0, 16'd0);
    tbl[19] = mk(4'b0110, 16'd0, 16'd0, 5'b00000, 32'd0, 32'd0, 2'd0, 16'd0);
    tbl[20] = mk(4'b0100, 16'd0, 16'd0, 5'b00000, 32'd0, 32'd0, 2'd0, 16'd0);
    #1;
    chk("reset_state", 128'(outs()), 128'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 21; i++) begin
      ni = tbl[i].ni;
      ns = tbl[i].ns;
      drive(tbl[i].in[3], tbl[i].in[2], tbl[i].in[1], tbl[i].in[0]);
      chk($sformatf("vec%0d", i), 128'(outs()), 128'({tbl[i].fl, tbl[i].ia, tbl[i].ha, tbl[i].nc, tbl[i].sc}));
    end
    // init=2, num=3, dense enables
    ni = 16'd2;
    ns = 16'd3;
    drive(1, 0, 0, 0);
    cnt = 0;
    for (int c = 0; c < 40; c++) begin
      drive(0, 1, 0, 0);
      if (!bus.reservoir_init_busy) break;
      cnt++;
    end
    chk("a_init_enables", 128'(cnt), 128'd8);
    chk("a_init_end", 128'({bus.reservoir_init_busy, bus.reservoir_busy, bus.sample_cntr}), 128'({1'b0, 1'b1, 16'd2}));
    drive(0, 0, 0, 1);
    writes = 0;
    for (int c = 0; c < 40; c++) begin
      drive(0, 1, 1, 0);
      if (c == 0) chk("a_filled_first", 128'(bus.reservoir_filled), 128'd1);
      if (!bus.reservoir_busy) break;
      chk($sformatf("a_write%0d", writes), 128'({bus.history_wr_en, bus.history_addr, bus.input_addr}),
          128'({1'b1, 32'(writes), 32'(2 + writes / 4)}));
      writes++;
    end
    chk("a_writes", 128'(writes), 128'd12);
    chk("a_busy_fall_addr", 128'(bus.input_addr), 128'd5);
    drive(0, 0, 0, 0);
    chk("a_done", 128'({flags(), bus.input_addr}), 128'({5'b00000, 32'd3}));
    // init=0, num=2, controller records only while filled
    ni = 16'd0;
    ns = 16'd2;
    drive(1, 0, 0, 0);
    drive(0, 0, 0, 0);
    chk("b_init0", 128'({bus.reservoir_init_busy, bus.reservoir_busy}), 128'(2'b01));
    drive(0, 0, 0, 1);
    he_auto = 1'b1;
    writes = 0;
    nf0 = 0;
    nf1 = 0;
    for (int c = 0; c < 40; c++) begin
      drive(0, 1, 0, 0);
      if (!bus.reservoir_busy) break;
      if (bus.reservoir_filled) nf1++;
      else nf0++;
      if (bus.history_wr_en) begin
        chk($sformatf("b_write%0d", writes), 128'(bus.history_addr), 128'(writes));
        writes++;
      end
    end
    he_auto = 1'b0;
    chk("b_unfilled", 128'(nf0), 128'd4);
    chk("b_filled", 128'(nf1), 128'd4);
    chk("b_writes", 128'(writes), 128'd4);
    chk("b_hist_end", 128'(bus.history_addr), 128'd4);
    // init=1, num=2, enable one cycle in three, history_en on alternate accepted enables
    ni = 16'd1;
    ns = 16'd2;
    drive(1, 0, 0, 0);
    repeat (4) drive(0, 1, 0, 0);
    drive(0, 0, 0, 1);
    k = 0;
    for (int c = 0; c < 60 && k < 8; c++) begin
      if (c % 3 == 0) begin
        drive(0, 1, logic'(k % 2 == 0), 0);
        chk($sformatf("c_adv%0d", k), 128'({bus.input_rd_en, bus.history_wr_en, bus.node_cntr, bus.sample_cntr, bus.history_addr}),
            128'({1'b1, logic'(k % 2 == 0), 2'(k % 4), 16'(k / 4), 32'((k + 1) / 2)}));
        k++;
      end else begin
        drive(0, 0, 1, 0);
        chk("c_gap", 128'({bus.input_rd_en, bus.history_wr_en}), 128'd0);
      end
    end
    drive(0, 0, 0, 0);
    chk("c_end", 128'({bus.reservoir_busy, bus.history_addr, bus.sample_cntr}), 128'({1'b0, 32'd4, 16'd2}));
    // abort mid-RUN at sample_cntr=1
    ni = 16'd1;
    ns = 16'd3;
    drive(1, 0, 0, 0);
    repeat (4) drive(0, 1, 0, 0);
    drive(0, 0, 0, 1);
    repeat (4) drive(0, 1, 1, 0);
    drive(1, 1, 1, 0);
    chk("d_abort_cycle", 128'({bus.history_wr_en, bus.sample_cntr}), 128'({1'b0, 16'd1}));
    drive(0, 0, 0, 0);
    chk("d_after", 128'({flags(), bus.node_cntr, bus.sample_cntr, bus.history_addr, bus.input_addr}),
        128'({5'b11000, 2'd0, 16'd0, 32'd0, 32'd0}));
    // async reset between edges mid-INIT
    drive(0, 1, 0, 0);
    drive(0, 1, 0, 0);
    @(posedge clk);
    #1;
    chk("e_pre", 128'(bus.node_cntr), 128'd2);
    #1;
    rst = 1'b1;
    #1;
    chk("e_async", 128'(outs()), 128'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      drive(0, 1, 1, 0);
      chk($sformatf("e_idle%0d", c), 128'(outs()), 128'd0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
